switch_dev_if: RTL and testbench

- Device-side endpoint of the switch port protocol.
- Drives the port's TX half: validtx/acktx 4-phase handshake, plus destination address and data.
- Consumes the port's RX half: validrx/ackrx 4-phase handshake.
- Presents simple push/pop interfaces to local device logic, with a small TX queue and a 1-entry RX holding register.

---
 rtl/switch_dev_if.sv | 162 ++++++++++++++++
 tb/tb_switch_dev_if.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_dev_if.sv
// Device-side endpoint of the switch port: queued 4-phase TX toward the port,
// 4-phase RX into a single holding register with a post-release guard window.
module switch_dev_if #(
  parameter int AW_DEV   = 2,
  parameter int DW       = 4,
  parameter int TX_AW    = 1,
  parameter int RX_GUARD = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW-1:0]     tx_dat_i,
  input  logic [AW_DEV-1:0] tx_adr_i,
  input  logic              tx_push_i,
  output logic              tx_ready_o,
  output logic              tx_done_o,
  output logic [DW-1:0]     sw_dat_o,
  output logic [AW_DEV-1:0] sw_adr_o,
  output logic              validtx_o,
  input  logic              acktx_i,
  input  logic [DW-1:0]     sw_dat_i,
  input  logic              validrx_i,
  output logic              ackrx_o,
  output logic [DW-1:0]     rx_dat_o,
  output logic              rx_valid_o,
  input  logic              rx_pop_i
);
  localparam int DEPTH = 1 << TX_AW;
  localparam int EW    = AW_DEV + DW;
  localparam int CW    = $clog2(RX_GUARD + 1);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_st_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_GRD} rx_st_t;

  // TX queue
  logic [EW-1:0]  mem_q [DEPTH];
  logic [TX_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic           full, empty, push_ok, pop;
  logic           tx_ready_q, tx_ready_d;

  assign full    = (wptr_q[TX_AW] != rptr_q[TX_AW]) &&
                   (wptr_q[TX_AW-1:0] == rptr_q[TX_AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign push_ok = tx_push_i & ~full;

  always_comb begin
    wptr_d     = wptr_q + (TX_AW+1)'(push_ok);
    rptr_d     = rptr_q + (TX_AW+1)'(pop);
    tx_ready_d = ~((wptr_d[TX_AW] != rptr_d[TX_AW]) &&
                   (wptr_d[TX_AW-1:0] == rptr_d[TX_AW-1:0]));
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i)
    if (push_ok) mem_q[wptr_q[TX_AW-1:0]] <= {tx_adr_i, tx_dat_i};

  // TX FSM
  tx_st_t            tx_st_q, tx_st_d;
  logic              validtx_q, validtx_d, tx_done_q, tx_done_d;
  logic [AW_DEV-1:0] sw_adr_q, sw_adr_d;
  logic [DW-1:0]     sw_dat_q, sw_dat_d;

  always_comb begin
    tx_st_d   = tx_st_q;
    validtx_d = validtx_q;
    tx_done_d = 1'b0;
    sw_adr_d  = sw_adr_q;
    sw_dat_d  = sw_dat_q;
    pop       = 1'b0;
    case (tx_st_q)
      T_IDLE: if (!empty) begin
        pop                  = 1'b1;
        {sw_adr_d, sw_dat_d} = mem_q[rptr_q[TX_AW-1:0]];
        validtx_d            = 1'b1;
        tx_st_d              = T_REQ;
      end
      T_REQ: if (acktx_i) begin
        validtx_d = 1'b0;
        tx_st_d   = T_REL;
      end
      T_REL: if (!acktx_i) begin
        tx_done_d = 1'b1;
        tx_st_d   = T_IDLE;
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  // RX FSM
  rx_st_t        rx_st_q, rx_st_d;
  logic          ackrx_q, ackrx_d, rx_valid_q, rx_valid_d;
  logic [DW-1:0] rx_dat_q, rx_dat_d;
  logic [CW-1:0] grd_q, grd_d;

  always_comb begin
    rx_st_d    = rx_st_q;
    ackrx_d    = ackrx_q;
    rx_dat_d   = rx_dat_q;
    rx_valid_d = rx_valid_q;
    grd_d      = grd_q;
    if (rx_pop_i && rx_valid_q) rx_valid_d = 1'b0;
    case (rx_st_q)
      // Capture gates on the registered full flag, so a same-cycle pop cannot enable it.
      R_IDLE: if (validrx_i && !rx_valid_q) begin
        rx_dat_d   = sw_dat_i;
        rx_valid_d = 1'b1;
        ackrx_d    = 1'b1;
        rx_st_d    = R_ACK;
      end
      R_ACK: if (!validrx_i) begin
        ackrx_d = 1'b0;
        grd_d   = CW'(RX_GUARD);
        rx_st_d = R_GRD;
      end
      R_GRD: begin
        grd_d = (grd_q == '0) ? '0 : grd_q - CW'(1);
        if (grd_q <= CW'(1)) rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      tx_ready_q <= 1'b1;
      tx_st_q    <= T_IDLE;
      validtx_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      sw_adr_q   <= '0;
      sw_dat_q   <= '0;
      rx_st_q    <= R_IDLE;
      ackrx_q    <= 1'b0;
      rx_dat_q   <= '0;
      rx_valid_q <= 1'b0;
      grd_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tx_ready_q <= tx_ready_d;
      tx_st_q    <= tx_st_d;
      validtx_q  <= validtx_d;
      tx_done_q  <= tx_done_d;
      sw_adr_q   <= sw_adr_d;
      sw_dat_q   <= sw_dat_d;
      rx_st_q    <= rx_st_d;
      ackrx_q    <= ackrx_d;
      rx_dat_q   <= rx_dat_d;
      rx_valid_q <= rx_valid_d;
      grd_q      <= grd_d;
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign tx_done_o  = tx_done_q;
  assign validtx_o  = validtx_q;
  assign sw_adr_o   = sw_adr_q;
  assign sw_dat_o   = sw_dat_q;
  assign ackrx_o    = ackrx_q;
  assign rx_dat_o   = rx_dat_q;
  assign rx_valid_o = rx_valid_q;
endmodule

// File: tb/tb_switch_dev_if.sv
// Directed + randomized bench for switch_dev_if, checked every cycle against a
// transaction-level model (queue of pending sends, handshake phases, guard count).
module tb_switch_dev_if;
  localparam int AW = 2, DW = 4, TX_AW = 1, RX_GUARD = 2;
  localparam int DEPTH = 1 << TX_AW;

  logic          clk_i = 1'b0, rst_i = 1'b1;
  logic [DW-1:0] tx_dat_i = '0, sw_dat_i = '0;
  logic [AW-1:0] tx_adr_i = '0;
  logic          tx_push_i = 0, acktx_i = 0, validrx_i = 0, rx_pop_i = 0;
  logic          tx_ready_o, tx_done_o, validtx_o, ackrx_o, rx_valid_o;
  logic [DW-1:0] sw_dat_o, rx_dat_o;
  logic [AW-1:0] sw_adr_o;

  switch_dev_if #(.AW_DEV(AW), .DW(DW), .TX_AW(TX_AW), .RX_GUARD(RX_GUARD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_dat_i(tx_dat_i), .tx_adr_i(tx_adr_i), .tx_push_i(tx_push_i),
    .tx_ready_o(tx_ready_o), .tx_done_o(tx_done_o),
    .sw_dat_o(sw_dat_o), .sw_adr_o(sw_adr_o), .validtx_o(validtx_o), .acktx_i(acktx_i),
    .sw_dat_i(sw_dat_i), .validrx_i(validrx_i), .ackrx_o(ackrx_o),
    .rx_dat_o(rx_dat_o), .rx_valid_o(rx_valid_o), .rx_pop_i(rx_pop_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending sends, current send and its phase, RX holding slot.
  bit [AW+DW-1:0] q[$];
  bit [AW-1:0]    m_adr;
  bit [DW-1:0]    m_dat, m_rdat;
  bit             m_vtx, m_done, m_ack, m_rv;
  bit             tx_busy, tx_acked;   // a send is outstanding / port has acknowledged it
  bit             rx_held;             // port request acknowledged, waiting for release
  int             guard_left;          // cycles of guard still to elapse

  task automatic model_reset();
    q.delete();
    m_adr = '0; m_dat = '0; m_rdat = '0;
    m_vtx = 0; m_done = 0; m_ack = 0; m_rv = 0;
    tx_busy = 0; tx_acked = 0; rx_held = 0; guard_left = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_ready"}, tx_ready_o, q.size() < DEPTH);
    chk({ph, "_done"},  tx_done_o,  m_done);
    chk({ph, "_vtx"},   validtx_o,  m_vtx);
    chk({ph, "_adr"},   sw_adr_o,   m_adr);
    chk({ph, "_dat"},   sw_dat_o,   m_dat);
    chk({ph, "_ackrx"}, ackrx_o,    m_ack);
    chk({ph, "_rdat"},  rx_dat_o,   m_rdat);
    chk({ph, "_rv"},    rx_valid_o, m_rv);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check after it.
  task automatic cyc(input bit push, input bit [AW-1:0] adr, input bit [DW-1:0] dat,
                     input bit ack, input bit vrx, input bit [DW-1:0] sdat, input bit pop,
                     input string ph);
    bit was_full, rv_pre;
    tx_push_i = push; tx_adr_i = adr; tx_dat_i = dat;
    acktx_i = ack; validrx_i = vrx; sw_dat_i = sdat; rx_pop_i = pop;
    was_full = (q.size() == DEPTH);
    rv_pre   = m_rv;
    m_done   = 0;
    if (!tx_busy) begin
      if (q.size() > 0) begin
        {m_adr, m_dat} = q.pop_front();
        tx_busy = 1; tx_acked = 0; m_vtx = 1;
      end
    end else if (!tx_acked) begin
      if (ack) begin tx_acked = 1; m_vtx = 0; end
    end else if (!ack) begin
      tx_busy = 0; m_done = 1;
    end
    if (push && !was_full) q.push_back({adr, dat});
    if (pop && rv_pre) m_rv = 0;
    if (guard_left > 0) begin
      guard_left--;
    end else if (rx_held) begin
      if (!vrx) begin rx_held = 0; m_ack = 0; guard_left = RX_GUARD; end
    end else if (vrx && !rv_pre) begin
      m_rdat = sdat; m_rv = 1; m_ack = 1; rx_held = 1;
    end
    @(posedge clk_i);
    #1;
    check_all(ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, ph);
  endtask

  // Reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic async_reset(input string ph);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk({ph, "_rst_vtx"},   validtx_o,  0);
    chk({ph, "_rst_ackrx"}, ackrx_o,    0);
    chk({ph, "_rst_ready"}, tx_ready_o, 1);
    chk({ph, "_rst_rv"},    rx_valid_o, 0);
    check_all({ph, "_rst"});
    @(posedge clk_i); #1;
    tx_push_i = 0; acktx_i = 0; validrx_i = 0; rx_pop_i = 0;
    rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all("rst0");
    rst_i = 1'b0;

    // 1: single send and full handshake
    cyc(1, 2'b10, 4'hA, 0, 0, 0, 0, "t1");
    cyc(0, 0, 0, 0, 0, 0, 0, "t1");
    chk("t1_vtx_up", validtx_o, 1);
    chk("t1_adr_val", sw_adr_o, 2);
    chk("t1_dat_val", sw_dat_o, 4'hA);
    cyc(0, 0, 0, 0, 0, 0, 0, "t1");
    cyc(0, 0, 0, 1, 0, 0, 0, "t1");
    chk("t1_vtx_dn", validtx_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, "t1");
    chk("t1_done_pulse", tx_done_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, "t1");
    chk("t1_done_once", tx_done_o, 0);

    // 2: overfill the queue while the port withholds ack
    cyc(1, 2'd1, 4'h1, 0, 0, 0, 0, "t2");
    cyc(1, 2'd2, 4'h2, 0, 0, 0, 0, "t2");
    cyc(1, 2'd3, 4'h3, 0, 0, 0, 0, "t2");
    chk("t2_full", tx_ready_o, 0);
    cyc(1, 2'd0, 4'h4, 0, 0, 0, 0, "t2");
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, m_vtx, 0, 0, 0, "t2");
    chk("t2_drained", tx_ready_o, 1);

    // 3: RX capture, release, stale request ignored during guard
    cyc(0, 0, 0, 0, 1, 4'h5, 0, "t3");
    chk("t3_rdat", rx_dat_o, 4'h5);
    chk("t3_ack", ackrx_o, 1);
    cyc(0, 0, 0, 0, 1, 4'h5, 0, "t3");
    cyc(0, 0, 0, 0, 0, 4'h5, 0, "t3");
    chk("t3_ackdn", ackrx_o, 0);
    cyc(0, 0, 0, 0, 1, 4'h9, 1, "t3");
    cyc(0, 0, 0, 0, 1, 4'h9, 0, "t3");
    chk("t3_guard_nocap", rx_valid_o, 0);
    cyc(0, 0, 0, 0, 1, 4'h9, 0, "t3");
    chk("t3_recap", rx_dat_o, 4'h9);

    // 4: back-pressure from a full holding register
    cyc(0, 0, 0, 0, 0, 0, 0, "t4");
    idle(3, "t4");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 4'hC, 0, "t4");
    chk("t4_stall", ackrx_o, 0);
    cyc(0, 0, 0, 0, 1, 4'hC, 1, "t4");
    chk("t4_popped", rx_valid_o, 0);
    chk("t4_pop_nocap", ackrx_o, 0);
    cyc(0, 0, 0, 0, 1, 4'hC, 0, "t4");
    chk("t4_cap", rx_dat_o, 4'hC);

    // 5: async reset in T_REQ / R_ACK
    async_reset("t5a");
    cyc(1, 2'd3, 4'h7, 0, 1, 4'h6, 0, "t5");
    cyc(0, 0, 0, 0, 1, 4'h6, 0, "t5");
    async_reset("t5");
    idle(2, "t5_post");

    // 6: randomized concurrent traffic with a port that mostly follows protocol
    for (int i = 0; i < 3000; i++) begin
      bit ack, vrx;
      ack = ($urandom_range(0, 2) == 0) ? acktx_i : m_vtx;
      vrx = m_ack ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1);
      cyc($urandom_range(0, 1), AW'($urandom), DW'($urandom), ack, vrx,
          DW'($urandom), $urandom_range(0, 2) == 0, "rnd");
      if (i % 600 == 599) async_reset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
